// File: rtl/id_stage_pipe.sv
// Decode stage: decodes the IF/ID word, reads an internal register file with write-through
// bypass, bubbles on load-use hazards and holds the result behind a valid/ready handshake.
module id_stage_pipe #(
  parameter int XLEN        = 32,
  parameter int NREGS       = 32,
  parameter int HAZARD_EN   = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [XLEN+31:0]       i_if_id_regs,     // {pc, inst}
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [2*XLEN+37:0]     o_id_ex_regs,     // packed id_ex_regs_t
  output logic [XLEN-1:0]        o_reg_data1,
  output logic [XLEN-1:0]        o_reg_data2,
  output logic                   o_valid,
  input  logic                   i_ready,
  input  logic                   i_flush,
  input  logic                   i_reg_we,
  input  logic [4:0]             i_write_reg,
  input  logic [XLEN-1:0]        i_write_reg_data,
  input  logic                   i_ex_valid,
  input  logic                   i_ex_is_load,
  input  logic [4:0]             i_ex_rd,
  output logic                   o_hazard,
  output logic                   o_illegal,
  output logic [STALL_CNT_W-1:0] o_stall_cnt
);

  localparam int RIDX_W = $clog2(NREGS);

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6f;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } if_id_regs_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [6:0]      opcode;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            alu_src;
  } id_ex_regs_t;

  if_id_regs_t       in_s;
  id_ex_regs_t       dec;
  logic [31:0]       inst;
  logic              adv;
  logic              wr_en;
  logic [XLEN-1:0]   rf_q [NREGS];

  logic              valid_q, valid_d;
  id_ex_regs_t       regs_q, regs_d;
  logic [XLEN-1:0]   data1_q, data1_d;
  logic [XLEN-1:0]   data2_q, data2_d;
  logic              illegal_q, illegal_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign in_s = i_if_id_regs;
  assign inst = in_s.inst;

  function automatic logic in_range(input logic [4:0] idx);
    return int'(idx) < NREGS;
  endfunction

  assign wr_en = i_reg_we && (i_write_reg != 5'd0) && in_range(i_write_reg);

  // A same-cycle writeback to the register being read wins over the stored value.
  function automatic logic [XLEN-1:0] read_op(input logic [4:0] idx);
    if (idx == 5'd0 || !in_range(idx)) return '0;
    if (wr_en && i_write_reg == idx)   return i_write_reg_data;
    return rf_q[idx[RIDX_W-1:0]];
  endfunction

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first so no latch is inferred.
    dec           = '0;
    dec.pc        = in_s.pc;
    dec.rd        = inst[11:7];
    dec.rs1       = inst[19:15];
    dec.rs2       = inst[24:20];
    dec.funct3    = inst[14:12];
    dec.funct7    = inst[31:25];
    dec.opcode    = inst[6:0];
    case (inst[6:0])
      OPC_LOAD: begin
        dec.imm = XLEN'($signed(inst[31:20]));
        {dec.reg_write, dec.mem_read, dec.alu_src} = 3'b111;
      end
      OPC_OP_IMM: begin
        dec.imm = XLEN'($signed(inst[31:20]));
        {dec.reg_write, dec.alu_src} = 2'b11;
      end
      OPC_JALR: begin
        dec.imm = XLEN'($signed(inst[31:20]));
        {dec.reg_write, dec.jump, dec.alu_src} = 3'b111;
      end
      OPC_STORE: begin
        dec.imm = XLEN'($signed({inst[31:25], inst[11:7]}));
        {dec.mem_write, dec.alu_src} = 2'b11;
      end
      OPC_BRANCH: begin
        dec.imm    = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
        dec.branch = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.imm = XLEN'($signed({inst[31:12], 12'b0}));
        {dec.reg_write, dec.alu_src} = 2'b11;
      end
      OPC_JAL: begin
        dec.imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
        {dec.reg_write, dec.jump} = 2'b11;
      end
      OPC_OP:  dec.reg_write = 1'b1;
      default: ;
    endcase
  end

  // Conservative: any source field match counts, whatever the opcode actually reads.
  assign o_hazard = (HAZARD_EN != 0) && i_valid && i_ex_valid && i_ex_is_load &&
                    (i_ex_rd != 5'd0) &&
                    (i_ex_rd == inst[19:15] || i_ex_rd == inst[24:20]);

  assign adv     = !valid_q || i_ready;
  assign o_ready = (adv && !o_hazard) || i_flush;

  always_comb begin
    valid_d     = valid_q;
    regs_d      = regs_q;
    data1_d     = data1_q;
    data2_d     = data2_q;
    illegal_d   = illegal_q;
    stall_cnt_d = stall_cnt_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (adv && o_hazard) begin
      valid_d = 1'b0;
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end else if (adv && i_valid) begin
      valid_d   = 1'b1;
      regs_d    = dec;
      data1_d   = read_op(dec.rs1);
      data2_d   = read_op(dec.rs2);
      illegal_d = !in_range(dec.rd) || !in_range(dec.rs1) || !in_range(dec.rs2);
    end else if (adv) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q     <= 1'b0;
      regs_q      <= '0;
      data1_q     <= '0;
      data2_q     <= '0;
      illegal_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      regs_q      <= regs_d;
      data1_q     <= data1_d;
      data2_q     <= data2_d;
      illegal_q   <= illegal_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // NOTE: the register file is architecturally cleared on reset, so this memory is reset like
  // ordinary flops rather than left uninitialised as a RAM would be.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wr_en) begin
      rf_q[i_write_reg[RIDX_W-1:0]] <= i_write_reg_data;
    end
  end

  assign o_valid      = valid_q;
  assign o_id_ex_regs = regs_q;
  assign o_reg_data1  = data1_q;
  assign o_reg_data2  = data2_q;
  assign o_illegal    = illegal_q;
  assign o_stall_cnt  = stall_cnt_q;

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised successor of the decode stage. Decodes the IF/ID instruction, reads an internal NREGS x XLEN register file, and holds the result in an output register with a valid/ready handshake.
- Adds three behaviours: a write-through bypass, load-use hazard bubbling with upstream backpressure, and a pipeline flush.
- Sits between the fetch stage and the execute stage.
- Also exports a saturating count of stall cycles for performance monitoring.

Parameters:
XLEN, 32, register data width (32 or 64)
NREGS, 32, architectural register count (16 = RV32E, 32 = RV32I); RIDX_W = $clog2(NREGS)
HAZARD_EN, 1, 1 enables load-use detection; 0 ties o_hazard low
STALL_CNT_W, 16, width of stall-cycle counter

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  synchronous, active-high reset
i_if_id_regs  in  if_id_regs_t  fetched pc/inst
i_valid  in  1  i_if_id_regs holds a valid instruction
o_ready  out  1  stage accepts i_if_id_regs this cycle
o_id_ex_regs  out  id_ex_regs_t  registered decode result (pc, imm, rd, rs1, rs2, control fields)
o_reg_data1  out  XLEN  registered rs1 operand
o_reg_data2  out  XLEN  registered rs2 operand
o_valid  out  1  output register holds a valid instruction
i_ready  in  1  execute stage accepts output this cycle
i_flush  in  1  kill instruction in output register and at input
i_reg_we  in  1  writeback enable
i_write_reg  in  5  writeback index
i_write_reg_data  in  XLEN  writeback data
i_ex_valid  in  1  execute stage holds a valid instruction
i_ex_is_load  in  1  that instruction is a load
i_ex_rd  in  5  its destination register
o_hazard  out  1  load-use bubble being inserted this cycle (combinational)
o_illegal  out  1  registered; decoded instruction named a register >= NREGS
o_stall_cnt  out  STALL_CNT_W  saturating count of hazard cycles

Behaviour:
- Reset (i_rst=1 at a rising edge):
  - o_valid=0, o_id_ex_regs='0, o_reg_data1/2=0, o_illegal=0, o_stall_cnt=0.
  - All register-file entries are cleared to 0.
  - Reset overrides flush, handshake and writeback in the same cycle.
- Register file:
  - Index 0 always reads 0; writes to index 0 are ignored.
  - Writes with i_write_reg >= NREGS are ignored.
- Write-through bypass: when i_reg_we=1, i_write_reg!=0 and it equals rs1 (or rs2), the operand captured in that cycle is i_write_reg_data, not the stale file value.
- Hazard detection, combinational, all conditions required:
  - HAZARD_EN=1, i_valid=1, i_ex_valid=1, i_ex_is_load=1, i_ex_rd!=0;
  - and i_ex_rd equals inst[19:15] or inst[24:20];
  - gating by opcode is not done (conservative).
  - When these hold, o_hazard=1.
- Advance condition: adv = !o_valid || i_ready.
- o_ready = adv && !o_hazard, or i_flush=1 (a flushed input is consumed and dropped).
- Output register update at each edge, in priority order:
  1. i_flush → o_valid<=0.
  2. adv && o_hazard → o_valid<=0 (bubble); the IF/ID input is held because o_ready=0.
  3. adv && i_valid → capture decode result and operands, o_valid<=1.
  4. adv && !i_valid → o_valid<=0.
  5. Otherwise (o_valid && !i_ready) → all outputs hold stable.
- Latency: one cycle from input acceptance to o_valid.
- Throughput: one instruction per cycle when there is no hazard and i_ready=1.
- o_illegal is captured with the instruction:
  - set if NREGS=16 and the MSB (bit 4) of rd, rs1 or rs2 is set;
  - the instruction is still passed through;
  - operands for out-of-range indices read 0.
- o_stall_cnt increments by 1 on each edge where o_hazard && adv && !i_flush. It saturates at all-ones and never wraps.
- Flush together with a hazard: the flush wins, no count increment, o_ready=1.
- A writeback in the same cycle as a read is always visible to that read via the bypass. No extra stall.

Test Plan:
- Reset then idle: assert i_rst 2 cycles, i_valid=0 → o_valid=0, o_ready=1, o_stall_cnt=0, reading x5 returns 0.
- Writeback then read: write x5=0xDEADBEEF; next cycle issue add x6,x5,x5 → one cycle later o_valid=1, o_reg_data1=o_reg_data2=0xDEADBEEF, rd=6. Write x0=0x1234 → x0 still reads 0.
- Bypass: in the same cycle as i_reg_we=1, i_write_reg=7, data=0xA5A5A5A5, issue an instruction with rs2=7 → o_reg_data2=0xA5A5A5A5.
- Load-use: EX holds lw x3 (i_ex_valid=1, i_ex_is_load=1, i_ex_rd=3), ID holds add x4,x3,x1 →
  - o_hazard=1 and o_ready=0 for that cycle;
  - next cycle o_valid=0 (bubble) and o_stall_cnt=1;
  - after the EX inputs clear, the add issues with o_valid=1.
- Backpressure and flush:
  - With o_valid=1 and i_ready=0 for 3 cycles, outputs stay bit-identical and o_ready=0.
  - Asserting i_flush then gives o_valid=0 next cycle, and the current input is dropped.
- Saturation and RV32E: with STALL_CNT_W=2, force 5 hazard cycles → o_stall_cnt stays 3. With NREGS=16, issue add x17,x1,x2 → o_illegal=1 and o_valid=1.
